// File: rtl/memu_pkg.sv
// rtl/memu_pkg.sv - shared types, exception codes and misalignment helper for the memory access unit
package memu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } memu_state_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } memop_t;

    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;

    // Offset bits below the access size must be zero; for 8B the 3-bit mask wraps to 3'b111.
    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
        logic [2:0] size_mask;
        size_mask  = (3'd1 << size) - 3'd1;
        misaligned = |(off & size_mask);
    endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane shift, strobe generation and load extension shared by store and load paths
module mem_align
    import memu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [OFF_W-1:0]  offset,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] st_data,
    output logic [STRB_W-1:0] st_strobe,
    output logic [DATA_W-1:0] ld_data
);

    logic [OFF_W+2:0]  shift;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] ld_mask;
    logic              ld_sign;
    logic [7:0]        byte_mask;
    logic [15:0]       strb_wide;

    assign shift     = {offset, 3'b000};
    assign st_data   = wdata << shift;
    assign raw       = rdata >> shift;
    assign strb_wide = {8'h00, byte_mask} << offset;
    assign st_strobe = strb_wide[STRB_W-1:0];

    // Contiguous byte-enable pattern for the access size, before lane shifting.
    always_comb begin
        byte_mask = 8'h00;
        case (size)
            MSIZE1:  byte_mask = 8'h01;
            MSIZE2:  byte_mask = 8'h03;
            MSIZE4:  byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
    end

    // Keep the accessed bits and extend; a full-width access passes raw through untouched.
    always_comb begin
        ld_mask = '0;
        ld_sign = 1'b0;
        case (size)
            MSIZE1: begin
                ld_mask[7:0] = '1;
                ld_sign      = raw[7];
            end
            MSIZE2: begin
                ld_mask[15:0] = '1;
                ld_sign       = raw[15];
            end
            MSIZE4: begin
                ld_mask[31:0] = '1;
                ld_sign       = raw[31];
            end
            default: begin
                ld_mask = '1;
                ld_sign = 1'b0;
            end
        endcase
        ld_data = (raw & ld_mask) | ((ld_sign && !is_unsigned) ? ~ld_mask : '0);
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - handshaked memory stage with bus request, alignment check and load extension; optional MEMU_LOAD_MISALIGN_EN
module mem_access_unit
    import memu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int STRB_W = DATA_W / 8,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              in_exception,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_exc,
    output logic [3:0]        out_exc_code,
    output logic              stall,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [1:0]        dreq_size,
    output logic [STRB_W-1:0] dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data
);

    memu_state_t       state_q, state_d;
    logic [1:0]        op_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              exc_q;
    logic [3:0]        exc_code_q;

    logic              accept;
    logic              is_mem;
    logic              misalign;
    logic              checked;
    logic              take_exc;
    logic              skip_bus;
    logic              data_cap;
    logic [DATA_W-1:0] st_data;
    logic [STRB_W-1:0] st_strobe;
    logic [DATA_W-1:0] ld_data;

    assign accept   = (state_q == IDLE) && in_valid;
    assign is_mem   = (in_op == MEM_LOAD) || (in_op == MEM_STORE);
    assign misalign = misaligned(3'(in_addr[OFF_W-1:0]), in_size);
`ifdef MEMU_LOAD_MISALIGN_EN
    assign checked  = is_mem;
`else
    assign checked  = (in_op == MEM_STORE);
`endif
    // An older exception outranks misalignment: the op is simply dropped.
    assign take_exc = checked && misalign && !in_exception;
    assign skip_bus = !is_mem || in_exception || (checked && misalign);
    assign data_cap = ((state_q == REQ) && dresp_addr_ok && dresp_data_ok) ||
                      ((state_q == WAIT) && dresp_data_ok);

    mem_align #(
        .DATA_W (DATA_W),
        .STRB_W (STRB_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .offset      (addr_q[OFF_W-1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (dresp_data),
        .st_data     (st_data),
        .st_strobe   (st_strobe),
        .ld_data     (ld_data)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        dreq_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = skip_bus ? DONE : REQ;
                end
            end
            REQ: begin
                dreq_valid = 1'b1;
                if (dresp_addr_ok) begin
                    state_d = dresp_data_ok ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dresp_data_ok) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the op at acceptance and capture aligned load data when the data phase completes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q       <= MEM_NONE;
            size_q     <= MSIZE1;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            exc_q      <= 1'b0;
            exc_code_q <= 4'd0;
        end else if (accept) begin
            op_q       <= in_op;
            size_q     <= in_size;
            uns_q      <= in_unsigned;
            addr_q     <= in_addr;
            wdata_q    <= in_wdata;
            rdata_q    <= '0;
            exc_q      <= take_exc;
            exc_code_q <= take_exc ? ((in_op == MEM_STORE) ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN) : 4'd0;
        end else if (data_cap && (op_q == MEM_LOAD)) begin
            rdata_q    <= ld_data;
        end
    end

    assign dreq_addr    = dreq_valid ? addr_q : '0;
    assign dreq_size    = dreq_valid ? size_q : 2'd0;
    assign dreq_strobe  = (dreq_valid && (op_q == MEM_STORE)) ? st_strobe : '0;
    assign dreq_data    = dreq_valid ? st_data : '0;
    assign out_rdata    = rdata_q;
    assign out_exc      = exc_q;
    assign out_exc_code = exc_code_q;
    assign stall        = (in_valid && !in_ready) || (in_valid && out_valid && !out_ready);

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench: directed vector table, corner sequences and randomized ops vs reference model
module tb_mem_access_unit;

`ifdef MEMU_LOAD_MISALIGN_EN
    localparam bit LMIS_EN = 1'b1;
`else
    localparam bit LMIS_EN = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        in_valid, in_ready;
    logic [1:0]  in_op, in_size;
    logic        in_unsigned;
    logic [63:0] in_addr, in_wdata;
    logic        in_exception;
    logic        out_valid, out_ready;
    logic [63:0] out_rdata;
    logic        out_exc;
    logic [3:0]  out_exc_code;
    logic        stall;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;

    int n_vec = 0;
    int n_err = 0;

    mem_access_unit dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_size       (in_size),
        .in_unsigned   (in_unsigned),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_exception  (in_exception),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_exc       (out_exc),
        .out_exc_code  (out_exc_code),
        .stall         (stall),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        int          req_cycles;
        logic [7:0]  strobe;
        logic [63:0] data;
        int          lat;
        logic        exc;
        logic [3:0]  code;
        logic [63:0] rdata;
    } exp_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        exc;
        int          a_dly;
        int          d_dly;
        int          r_dly;
        logic [63:0] rdata;
        exp_t        e;
    } vec_t;

    typedef struct packed {
        logic        rdy_acc;
        int          req_cycles;
        logic [63:0] r_addr;
        logic [63:0] r_data;
        logic [1:0]  r_size;
        logic [7:0]  r_strb;
        logic        unstable;
        int          lat;
        int          ov_cycles;
        logic        oexc;
        logic [3:0]  ocode;
        logic [63:0] ordata;
        int          busy_rdy;
        logic        ov_drop;
        logic        timeout;
    } obs_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: what the op should produce, from byte arithmetic on the access rules.
    function automatic exp_t model(input vec_t v);
        exp_t        e;
        int          bytes, off;
        bit          mem, mis, checked;
        logic [63:0] raw, lim, val;
        e       = '0;
        bytes   = 1 << v.size;
        off     = int'(v.addr[2:0]);
        mem     = (v.op == 2'd1) || (v.op == 2'd2);
        mis     = (v.addr % bytes) != 0;
        checked = (v.op == 2'd2) || LMIS_EN;
        e.lat   = 1;
        if (mem && !v.exc && checked && mis) begin
            e.exc  = 1'b1;
            e.code = (v.op == 2'd2) ? 4'd6 : 4'd4;
        end else if (mem && !v.exc) begin
            e.req_cycles = v.a_dly + 1;
            e.lat        = v.a_dly + v.d_dly + 2;
            e.data       = v.wdata << (8 * off);
            if (v.op == 2'd2) begin
                for (int b = 0; b < 8; b++) e.strobe[b] = (b >= off) && (b < off + bytes);
            end else begin
                raw = v.rdata >> (8 * off);
                if (bytes == 8) begin
                    e.rdata = raw;
                end else begin
                    lim = 64'd1 << (8 * bytes);
                    val = raw % lim;
                    if (!v.uns && val >= lim / 2) val = val - lim;
                    e.rdata = val;
                end
            end
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata, input logic exc,
                                input int a, input int d, input int r, input logic [63:0] rdata,
                                input int req, input logic [7:0] strb, input logic [63:0] data,
                                input int lat, input logic oexc, input logic [3:0] code,
                                input logic [63:0] ord);
        vec_t v;
        v = '0;
        v.op = op; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.exc = exc;
        v.a_dly = a; v.d_dly = d; v.r_dly = r; v.rdata = rdata;
        v.e.req_cycles = req; v.e.strobe = strb; v.e.data = data; v.e.lat = lat;
        v.e.exc = oexc; v.e.code = code; v.e.rdata = ord;
        return v;
    endfunction

    // Drive one op through acceptance, act as the bus agent, and observe the result handshake.
    task automatic run_op(input vec_t v, output obs_t o);
        int aok_cyc;
        bit done;
        o = '0;
        aok_cyc = 0;
        done = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = v.op; in_size = v.size; in_unsigned = v.uns;
        in_addr = v.addr; in_wdata = v.wdata; in_exception = v.exc; out_ready = 1'b0;
        o.rdy_acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_exception = 1'b0; in_op = 2'($urandom);
        in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
        for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
            @(negedge clk);
            dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = {$urandom, $urandom};
            if (dreq_valid) begin
                o.req_cycles++;
                if (o.req_cycles == 1) begin
                    o.r_addr = dreq_addr; o.r_data = dreq_data; o.r_size = dreq_size; o.r_strb = dreq_strobe;
                end else if (o.r_addr !== dreq_addr || o.r_data !== dreq_data ||
                             o.r_size !== dreq_size || o.r_strb !== dreq_strobe) begin
                    o.unstable = 1'b1;
                end
                if (aok_cyc == 0 && o.req_cycles == v.a_dly + 1) begin
                    dresp_addr_ok = 1'b1;
                    aok_cyc = cyc;
                    if (v.d_dly == 0) begin
                        dresp_data_ok = 1'b1;
                        dresp_data = v.rdata;
                    end
                end
            end else if (aok_cyc != 0 && v.d_dly != 0 && cyc == aok_cyc + v.d_dly) begin
                dresp_data_ok = 1'b1;
                dresp_data = v.rdata;
            end
            if (out_valid) begin
                o.ov_cycles++;
                if (o.lat == 0) o.lat = cyc;
                o.oexc = out_exc; o.ocode = out_exc_code; o.ordata = out_rdata;
                if (o.ov_cycles > v.r_dly) begin
                    out_ready = 1'b1;
                    done = 1;
                end
            end else if (o.lat != 0) begin
                o.ov_drop = 1'b1;
            end else if (in_ready) begin
                o.busy_rdy++;
            end
        end
        o.timeout = !done;
    endtask

    task automatic check_op(input string tag, input vec_t v, input obs_t o);
        chk({tag, ".accept_ready"}, 64'(o.rdy_acc), 64'd1);
        chk({tag, ".timeout"}, 64'(o.timeout), 64'd0);
        chk({tag, ".req_cycles"}, 64'(o.req_cycles), 64'(v.e.req_cycles));
        if (v.e.req_cycles > 0 && o.req_cycles > 0) begin
            chk({tag, ".dreq_addr"}, o.r_addr, v.addr);
            chk({tag, ".dreq_size"}, 64'(o.r_size), 64'(v.size));
            chk({tag, ".dreq_strobe"}, 64'(o.r_strb), 64'(v.e.strobe));
            chk({tag, ".dreq_data"}, o.r_data, v.e.data);
            chk({tag, ".dreq_stable"}, 64'(o.unstable), 64'd0);
        end
        chk({tag, ".latency"}, 64'(o.lat), 64'(v.e.lat));
        chk({tag, ".out_valid_cycles"}, 64'(o.ov_cycles), 64'(v.r_dly + 1));
        chk({tag, ".out_valid_drop"}, 64'(o.ov_drop), 64'd0);
        chk({tag, ".busy_in_ready"}, 64'(o.busy_rdy), 64'd0);
        chk({tag, ".out_exc"}, 64'(o.oexc), 64'(v.e.exc));
        chk({tag, ".out_exc_code"}, 64'(o.ocode), 64'(v.e.code));
        chk({tag, ".out_rdata"}, o.ordata, v.e.rdata);
    endtask

    vec_t tbl[13];
    vec_t rv;
    obs_t ob;

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_size = 2'd0; in_unsigned = 1'b0;
        in_addr = '0; in_wdata = '0; in_exception = 1'b0; out_ready = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.dreq_valid", 64'(dreq_valid), 64'd0);
        chk("reset.out_exc", 64'(out_exc), 64'd0);
        chk("reset.out_exc_code", 64'(out_exc_code), 64'd0);
        chk("reset.out_rdata", out_rdata, 64'd0);
        chk("reset.dreq_strobe", 64'(dreq_strobe), 64'd0);
        resetn = 1'b1;

        //            op    sz    u     addr       wdata      exc   a  d  r  rdata                    req strb   data                    lat exc   code  rdata
        tbl[0]  = mk(2'd2, 2'd2, 1'b0, 64'h1004, 64'hDEADBEEF, 1'b0, 0, 0, 0, 64'h0, 1, 8'hF0, 64'hDEADBEEF_00000000, 2, 1'b0, 4'd0, 64'h0);
        tbl[1]  = mk(2'd1, 2'd0, 1'b0, 64'h2003, 64'h0, 1'b0, 0, 3, 0, 64'h00000000_80000000, 1, 8'h00, 64'h0, 5, 1'b0, 4'd0, 64'hFFFFFFFF_FFFFFF80);
        tbl[2]  = mk(2'd2, 2'd3, 1'b0, 64'h3004, 64'h1111, 1'b0, 0, 0, 0, 64'h0, 0, 8'h00, 64'h0, 1, 1'b1, 4'd6, 64'h0);
        if (LMIS_EN)
            tbl[3] = mk(2'd1, 2'd1, 1'b1, 64'h3001, 64'h0, 1'b0, 1, 1, 0, 64'h00ABCD00, 0, 8'h00, 64'h0, 1, 1'b1, 4'd4, 64'h0);
        else
            tbl[3] = mk(2'd1, 2'd1, 1'b1, 64'h3001, 64'h0, 1'b0, 1, 1, 0, 64'h00ABCD00, 2, 8'h00, 64'h0, 4, 1'b0, 4'd0, 64'hABCD);
        tbl[4]  = mk(2'd1, 2'd3, 1'b0, 64'h4000, 64'h0, 1'b1, 0, 0, 3, 64'h12345678, 0, 8'h00, 64'h0, 1, 1'b0, 4'd0, 64'h0);
        tbl[5]  = mk(2'd1, 2'd2, 1'b0, 64'h5004, 64'h0, 1'b0, 2, 0, 0, 64'h87654321_00000000, 3, 8'h00, 64'h0, 4, 1'b0, 4'd0, 64'hFFFFFFFF_87654321);
        tbl[6]  = mk(2'd1, 2'd3, 1'b0, 64'h6000, 64'h0, 1'b0, 0, 1, 0, 64'h01234567_89ABCDEF, 1, 8'h00, 64'h0, 3, 1'b0, 4'd0, 64'h01234567_89ABCDEF);
        tbl[7]  = mk(2'd2, 2'd1, 1'b0, 64'h7006, 64'h1234, 1'b0, 1, 2, 0, 64'h0, 2, 8'hC0, 64'h12340000_00000000, 5, 1'b0, 4'd0, 64'h0);
        tbl[8]  = mk(2'd0, 2'd1, 1'b0, 64'h7001, 64'h0, 1'b0, 0, 0, 0, 64'h0, 0, 8'h00, 64'h0, 1, 1'b0, 4'd0, 64'h0);
        tbl[9]  = mk(2'd2, 2'd0, 1'b0, 64'h8007, 64'h55AA, 1'b0, 0, 0, 1, 64'h0, 1, 8'h80, 64'hAA000000_00000000, 2, 1'b0, 4'd0, 64'h0);
        tbl[10] = mk(2'd1, 2'd1, 1'b0, 64'h9002, 64'h0, 1'b0, 0, 0, 0, 64'h00000000_80010000, 1, 8'h00, 64'h0, 2, 1'b0, 4'd0, 64'hFFFFFFFF_FFFF8001);
        tbl[11] = mk(2'd2, 2'd2, 1'b0, 64'hA002, 64'h0, 1'b0, 0, 0, 0, 64'h0, 0, 8'h00, 64'h0, 1, 1'b1, 4'd6, 64'h0);
        tbl[12] = mk(2'd1, 2'd2, 1'b1, 64'hB004, 64'h0, 1'b0, 0, 0, 0, 64'h87654321_00000000, 1, 8'h00, 64'h0, 2, 1'b0, 4'd0, 64'h87654321);

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i], ob);
            check_op($sformatf("tbl%0d", i), tbl[i], ob);
        end

        // Held result with a follow-on op waiting: out_valid holds, stall raised.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_op = 2'd1; in_size = 2'd3; in_addr = 64'h4000; in_exception = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d.out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("hold%0d.in_ready", i), 64'(in_ready), 64'd0);
            chk($sformatf("hold%0d.stall", i), 64'(stall), 64'd1);
            chk($sformatf("hold%0d.dreq_valid", i), 64'(dreq_valid), 64'd0);
            chk($sformatf("hold%0d.out_rdata", i), out_rdata, 64'd0);
        end
        @(negedge clk);
        chk("hold3.stall", 64'(stall), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("release.in_ready", 64'(in_ready), 64'd1);
        chk("release.out_valid", 64'(out_valid), 64'd0);
        chk("release.stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_exception = 1'b0;
        @(negedge clk);
        chk("second.out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("second.in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;

        // Asynchronous reset while waiting for the data phase.
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'd1; in_size = 2'd3; in_addr = 64'hB000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstwait.dreq_valid_req", 64'(dreq_valid), 64'd1);
        dresp_addr_ok = 1'b1;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        chk("rstwait.dreq_valid_wait", 64'(dreq_valid), 64'd0);
        chk("rstwait.in_ready_wait", 64'(in_ready), 64'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("rstwait.in_ready", 64'(in_ready), 64'd1);
        chk("rstwait.out_valid", 64'(out_valid), 64'd0);
        chk("rstwait.dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rstwait.dreq_addr", dreq_addr, 64'd0);
        chk("rstwait.dreq_size", 64'(dreq_size), 64'd0);
        chk("rstwait.dreq_data", dreq_data, 64'd0);
        chk("rstwait.out_exc", 64'(out_exc), 64'd0);
        chk("rstwait.out_exc_code", 64'(out_exc_code), 64'd0);
        chk("rstwait.out_rdata", out_rdata, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("postrst.in_ready", 64'(in_ready), 64'd1);
        chk("postrst.out_valid", 64'(out_valid), 64'd0);
        chk("postrst.dreq_valid", 64'(dreq_valid), 64'd0);

        // Randomized ops checked against the reference model.
        for (int i = 0; i < 250; i++) begin
            rv = '0;
            rv.op    = ($urandom_range(0, 3) == 0) ? 2'd0 : (($urandom_range(0, 1) == 1) ? 2'd1 : 2'd2);
            rv.size  = 2'($urandom_range(0, 3));
            rv.uns   = 1'($urandom_range(0, 1));
            rv.addr  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) rv.addr = rv.addr & ~((64'd1 << rv.size) - 64'd1);
            rv.wdata = {$urandom, $urandom};
            rv.rdata = {$urandom, $urandom};
            rv.exc   = ($urandom_range(0, 7) == 0);
            rv.a_dly = $urandom_range(0, 3);
            rv.d_dly = $urandom_range(0, 3);
            rv.r_dly = $urandom_range(0, 2);
            rv.e     = model(rv);
            run_op(rv, ob);
            check_op($sformatf("rnd%0d", i), rv, ob);
        end

        @(negedge clk);
        out_ready = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
